// File: rtl/mem_debounce_counter.sv
// Debounced push-button press counter: 2-flop synchroniser, debounce FSM, press pulse, up/down counter.
// Optional macro COUNT_SAT_EN: counter saturates at 0 / MAX instead of wrapping.
module mem_debounce_counter #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             pulse,
  output logic             stable,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } db_state_e;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [7:0]       DB_LAST = 8'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  db_state_e        state_q;
  logic [7:0]       db_cnt_q;
  logic             pulse_q, stable_q;
  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; with blocking ones s2_q would see this edge's s1_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= IDLE;
      db_cnt_q <= '0;
      pulse_q  <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      pulse_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s2_q) begin
            state_q  <= PRESS_WAIT;
            db_cnt_q <= 8'd1;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q  <= HELD;
            pulse_q  <= 1'b1;
            stable_q <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + 8'd1;
          end
        end
        HELD: begin
          if (!s2_q) begin
            state_q  <= REL_WAIT;
            db_cnt_q <= 8'd1;
          end
        end
        REL_WAIT: begin
          if (s2_q) begin
            state_q  <= HELD;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q  <= IDLE;
            stable_q <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Load wins over a coincident pulse; that press is simply lost.
  // NOTE: count_d gets a default first so no path through this block infers a latch.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (pulse_q) begin
      if (up_dn) begin
`ifdef COUNT_SAT_EN
        if (count_q != CNT_MAX) count_d = count_q + 1'b1;
`else
        count_d = count_q + 1'b1;
`endif
      end else begin
`ifdef COUNT_SAT_EN
        if (count_q != '0) count_d = count_q - 1'b1;
`else
        count_d = count_q - 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count  = count_q;
  assign pulse  = pulse_q;
  assign stable = stable_q;
  assign tc     = (up_dn && (count_q == CNT_MAX)) || (!up_dn && (count_q == '0));

endmodule

// File: tb/tb_mem_debounce_counter.sv
// Directed self-checking bench for mem_debounce_counter (WIDTH=8, DB_CYCLES=4).
module tb_mem_debounce_counter;

  logic       clk = 1'b0;
  logic       reset, btn, up_dn, load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       pulse, stable, tc;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int pulse_base;

  mem_debounce_counter #(.WIDTH(8), .DB_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .up_dn   (up_dn),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .pulse   (pulse),
    .stable  (stable),
    .tc      (tc)
  );

  always #5 clk = ~clk;

  // Pulses are tallied away from the active edge.
  always @(negedge clk) if (pulse === 1'b1) pulse_cnt++;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full press held 8 cycles then released 8 cycles.
  task automatic press();
    btn = 1'b1;
    tick(8);
    btn = 1'b0;
    tick(8);
  endtask

  initial begin
    // 1. Reset dominates btn and load
    reset = 1'b1; btn = 1'b1; load = 1'b1; load_val = 8'hAA; up_dn = 1'b1;
    tick(2);
    check("reset_count",  32'(count),  32'h00);
    check("reset_pulse",  32'(pulse),  32'h0);
    check("reset_stable", 32'(stable), 32'h0);
    check("reset_tc",     32'(tc),     32'h0);
    reset = 1'b0; btn = 1'b0; load = 1'b0;
    tick(4);
    check("idle_count", 32'(count), 32'h00);

    // 2. Clean press: pulse exactly after E5, count at E6
    pulse_base = pulse_cnt;
    btn = 1'b1;
    tick(5);
    check("press_e4_no_pulse", 32'(pulse_cnt - pulse_base), 32'd0);
    tick(1);
    check("press_e5_pulse",  32'(pulse),  32'h1);
    check("press_e5_stable", 32'(stable), 32'h1);
    check("press_e5_count",  32'(count),  32'h00);
    tick(1);
    check("press_e6_pulse", 32'(pulse), 32'h0);
    check("press_e6_count", 32'(count), 32'h01);
    tick(3);
    check("press_one_pulse", 32'(pulse_cnt - pulse_base), 32'd1);
    // Release: stable drops at E5, no pulse
    pulse_base = pulse_cnt;
    btn = 1'b0;
    tick(5);
    check("rel_e4_stable", 32'(stable), 32'h1);
    tick(1);
    check("rel_e5_stable", 32'(stable), 32'h0);
    tick(4);
    check("rel_no_pulse", 32'(pulse_cnt - pulse_base), 32'd0);
    check("rel_count",    32'(count), 32'h01);

    // 3. Bounce shorter than DB_CYCLES
    pulse_base = pulse_cnt;
    btn = 1'b1; tick(2);
    btn = 1'b0; tick(1);
    btn = 1'b1; tick(2);
    btn = 1'b0; tick(10);
    check("bounce_no_pulse", 32'(pulse_cnt - pulse_base), 32'd0);
    check("bounce_count",    32'(count),  32'h01);
    check("bounce_stable",   32'(stable), 32'h0);

    // 4. Boundaries: up at MAX, down at 0
    load_val = 8'hFF; load = 1'b1; tick(1); load = 1'b0;
    check("load_ff",     32'(count), 32'hFF);
    check("tc_up_max",   32'(tc),    32'h1);
    up_dn = 1'b1;
    press();
`ifdef COUNT_SAT_EN
    check("up_at_max", 32'(count), 32'hFF);
`else
    check("up_at_max", 32'(count), 32'h00);
`endif
    load_val = 8'h00; load = 1'b1; tick(1); load = 1'b0;
    up_dn = 1'b0;
    #1;
    check("tc_dn_zero", 32'(tc), 32'h1);
    press();
`ifdef COUNT_SAT_EN
    check("dn_at_zero", 32'(count), 32'h00);
    check("tc_dn_after", 32'(tc),   32'h1);
`else
    check("dn_at_zero", 32'(count), 32'hFF);
    check("tc_dn_after", 32'(tc),   32'h0);
`endif
    up_dn = 1'b1;
    #1;
`ifdef COUNT_SAT_EN
    check("tc_up_nonmax", 32'(tc), 32'h0);
`else
    check("tc_up_max2",   32'(tc), 32'h1);
`endif

    // 5. Load collides with pulse: load wins, press lost
    load_val = 8'h10; load = 1'b1; tick(1); load = 1'b0;
    btn = 1'b1;
    tick(6);
    check("coll_pulse_seen", 32'(pulse), 32'h1);
    load_val = 8'h5A; load = 1'b1;
    tick(1);
    load = 1'b0;
    check("coll_count", 32'(count), 32'h5A);
    tick(3);
    btn = 1'b0;
    tick(8);
    check("coll_count_after", 32'(count), 32'h5A);

    // 6. Reset aborts PRESS_WAIT; fresh debounce follows
    btn = 1'b1;
    tick(4);
    pulse_base = pulse_cnt;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_reset_count",  32'(count),  32'h00);
    check("mid_reset_stable", 32'(stable), 32'h0);
    tick(5);
    check("mid_reset_no_early_pulse", 32'(pulse_cnt - pulse_base), 32'd0);
    tick(1);
    check("mid_reset_pulse_e6", 32'(pulse), 32'h1);
    tick(1);
    check("mid_reset_count_inc", 32'(count), 32'h01);
    btn = 1'b0;
    tick(8);
    check("mid_reset_one_pulse", 32'(pulse_cnt - pulse_base), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
